// File: rtl/soc_ahb3_pkg.sv
// Shared AHB3 definitions: bridge FSM states, HTRANS/HRESP encodings and the
// HPROT bit positions used when translating protection attributes.
package soc_ahb3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int HPROT_DATA = 0;
    localparam int HPROT_PRIV = 1;

endpackage

// File: rtl/soc_apb4_pkg.sv
// Shared APB4 definitions: PPROT bit positions and the AHB->APB protection
// translation helper.
package soc_apb4_pkg;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    function automatic logic [2:0] ahb_to_pprot(input logic priv, input logic data);
        logic [2:0] prot;
        prot               = '0;
        prot[PPROT_PRIV]   = priv;
        prot[PPROT_NONSEC] = 1'b1;
        prot[PPROT_INSTR]  = ~data;
        return prot;
    endfunction

endpackage

// File: rtl/soc_ahb3_apb4_strb.sv
// Byte-strobe and legality decode for one AHB transfer: low address bits plus
// HSIZE give the active byte lanes and flag oversize or misaligned transfers.
module soc_ahb3_apb4_strb #(
    parameter int  XLEN = 32,
    localparam int SW   = XLEN / 8,
    localparam int AW   = (SW > 1) ? $clog2(SW) : 1
) (
    input  logic [AW-1:0] i_addr_lo,
    input  logic [2:0]    i_hsize,
    output logic [SW-1:0] o_strb,
    output logic          o_illegal
);

    localparam int LOG_SW = $clog2(SW);

    int w_lo;
    int w_bytes;

    always_comb begin
        // The modulo keeps a one-byte bus from seeing a phantom lane offset.
        w_lo      = int'(i_addr_lo) % SW;
        w_bytes   = 1 << i_hsize;
        o_illegal = (int'(i_hsize) > LOG_SW) || ((w_lo % w_bytes) != 0);
        for (int i = 0; i < SW; i++) begin
            o_strb[i] = (i >= w_lo) && (i < w_lo + w_bytes);
        end
    end

endmodule

// File: rtl/soc_ahb3_apb4_bridge.sv
// AHB3-Lite slave to APB4 master bridge: one APB access per AHB transfer,
// two-cycle ERROR response for illegal sizes and APB slave errors.
module soc_ahb3_apb4_bridge
    import soc_ahb3_pkg::*;
    import soc_apb4_pkg::*;
#(
    parameter int PLEN = 32,
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              hsel_i,
    input  logic [PLEN-1:0]   haddr_i,
    input  logic [XLEN-1:0]   hwdata_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [2:0]        hburst_i,
    input  logic [XLEN/8-1:0] hprot_i,
    input  logic [1:0]        htrans_i,
    input  logic              hmastlock_i,
    output logic [XLEN-1:0]   hrdata_o,
    output logic              hready_o,
    output logic              hresp_o,

    output logic              psel_o,
    output logic              penable_o,
    output logic [PLEN-1:0]   paddr_o,
    output logic              pwrite_o,
    output logic [XLEN-1:0]   pwdata_o,
    output logic [XLEN/8-1:0] pstrb_o,
    output logic [2:0]        pprot_o,
    input  logic [XLEN-1:0]   prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    localparam int SW = XLEN / 8;
    localparam int AW = (SW > 1) ? $clog2(SW) : 1;

    bridge_state_e   r_state;
    bridge_state_e   w_next_state;
    logic            w_accept;
    logic            w_illegal;
    logic [SW-1:0]   w_strb;
    logic            w_unused;

    logic [PLEN-1:0] r_paddr;
    logic            r_pwrite;
    logic [XLEN-1:0] r_pwdata;
    logic [SW-1:0]   r_pstrb;
    logic [2:0]      r_pprot;

    assign w_unused = ^{hburst_i, hmastlock_i, hprot_i};

    soc_ahb3_apb4_strb #(
        .XLEN (XLEN)
    ) u_strb (
        .i_addr_lo (haddr_i[AW-1:0]),
        .i_hsize   (hsize_i),
        .o_strb    (w_strb),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch
        w_next_state = r_state;
        hready_o     = 1'b1;
        hresp_o      = HRESP_OKAY;
        psel_o       = 1'b0;
        penable_o    = 1'b0;
        hrdata_o     = '0;
        w_accept     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_IDLE;
            end
            ST_WDATA: begin
                hready_o     = 1'b0;
                w_next_state = ST_SETUP;
            end
            ST_SETUP: begin
                hready_o     = 1'b0;
                psel_o       = 1'b1;
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (!pready_i) begin
                    hready_o = 1'b0;
                end else if (pslverr_i) begin
                    hready_o     = 1'b0;
                    w_next_state = ST_ERR1;
                end else begin
                    w_next_state = ST_IDLE;
                    if (!r_pwrite) begin
                        hrdata_o = prdata_i;
                    end
                end
            end
            ST_ERR1: begin
                hready_o     = 1'b0;
                hresp_o      = HRESP_ERROR;
                w_next_state = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_o      = HRESP_ERROR;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // A transfer completing this cycle may be followed immediately by the next one.
        w_accept = hsel_i && hready_o &&
                   ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));
        if (w_accept) begin
            if (w_illegal) begin
                w_next_state = ST_ERR1;
            end else if (hwrite_i) begin
                w_next_state = ST_WDATA;
            end else begin
                w_next_state = ST_SETUP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
        end else begin
            if (w_accept && !w_illegal) begin
                r_paddr  <= haddr_i;
                r_pwrite <= hwrite_i;
                r_pstrb  <= hwrite_i ? w_strb : '0;
                r_pprot  <= ahb_to_pprot(hprot_i[HPROT_PRIV], hprot_i[HPROT_DATA]);
            end
            if (r_state == ST_WDATA) begin
                r_pwdata <= hwdata_i;
            end
        end
    end

    assign paddr_o  = r_paddr;
    assign pwrite_o = r_pwrite;
    assign pwdata_o = r_pwdata;
    assign pstrb_o  = r_pstrb;
    assign pprot_o  = r_pprot;

endmodule
